// File: rtl/indicator_scheduler.sv
// Round-robin time-share of the 2-bit LED state indicator between N_REQ requesters.
// Optional INDICATOR_PREEMPT_EN: requester 0 aborts any other owner's dwell.
module indicator_scheduler #(
   parameter int                 N_REQ      = 4,
   parameter int                 STATE_W    = 2,
   parameter int                 DWELL      = 8,
   parameter logic [STATE_W-1:0] IDLE_STATE = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*STATE_W-1:0] req_state,
   output logic [STATE_W-1:0]       state,
   output logic [N_REQ-1:0]         grant,
   output logic                     busy,
   output logic                     done
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(DWELL) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   typedef enum logic {IDLE, SHOW} fsm_t;

   fsm_t               fsm;
   logic [PTR_W-1:0]   ptr;
   logic [CNT_W-1:0]   cnt;

   logic               win_vld;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W:0]     sum;
   logic [STATE_W-1:0] win_state;
   logic [N_REQ-1:0]   win_grant;
   logic [PTR_W-1:0]   win_ptr;

   // first set req bit at or above ptr, wrapping modulo N_REQ
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      sum     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
         if (!win_vld && req[sum[PTR_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = sum[PTR_W-1:0];
         end
      end
   end

   assign win_state = req_state[win_idx*STATE_W +: STATE_W];
   assign win_grant = N_REQ'(1) << win_idx;
   assign win_ptr   = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm   <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         state <= IDLE_STATE;
         grant <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (win_vld) begin
                  fsm   <= SHOW;
                  busy  <= 1'b1;
                  state <= win_state;
                  grant <= win_grant;
                  ptr   <= win_ptr;
                  cnt   <= CNT_LOAD;
                  done  <= (DWELL == 1);
               end
            end
            SHOW: begin
`ifdef INDICATOR_PREEMPT_EN
               if (req[0] && !grant[0]) begin
                  state <= req_state[STATE_W-1:0];
                  grant <= N_REQ'(1);
                  ptr   <= PTR_W'(1);
                  cnt   <= CNT_LOAD;
                  done  <= (DWELL == 1);
               end else
`endif
               if (cnt != '0) begin
                  cnt  <= cnt - 1'b1;
                  done <= (cnt == CNT_W'(1));
               end else if (win_vld) begin
                  // back-to-back regrant; ptr already moved past the old owner
                  state <= win_state;
                  grant <= win_grant;
                  ptr   <= win_ptr;
                  cnt   <= CNT_LOAD;
                  done  <= (DWELL == 1);
               end else begin
                  fsm   <= IDLE;
                  state <= IDLE_STATE;
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_indicator_scheduler.sv
// Scoreboard bench for indicator_scheduler (N_REQ=4, DWELL=8): expected
// {state,grant,busy,done} queued per edge, compared on the following negedge.
module tb_indicator_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] req_state;
   logic [1:0] state;
   logic [3:0] grant;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   indicator_scheduler #(.N_REQ(4), .STATE_W(2), .DWELL(8), .IDLE_STATE(2'd0)) dut (
      .clk(clk), .rst(rst), .req(req), .req_state(req_state),
      .state(state), .grant(grant), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (state,grant,busy,done)", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [7:0] e;
         string      t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk(t, 32'({state, grant, busy, done}), 32'(e));
      end
   end

   // one edge: inputs already set; queue what the outputs must be after it
   task automatic tick(input string tag, input logic [1:0] st, input logic [3:0] gr,
                       input logic bs, input logic dn);
      @(posedge clk);
      exp_q.push_back({st, gr, bs, dn});
      tag_q.push_back(tag);
      #1;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, 2'd0, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      idle("reset", 2);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      req_state = '0;
      @(negedge clk);

      // reset then quiet idle
      do_reset();
      idle("idle", 10);

      // single requester 2, code 3
      req = 4'b0100;
      req_state = 8'b00_11_00_00;
      for (int k = 0; k < 8; k++) begin
         tick("single", 2'd3, 4'b0100, 1'b1, k == 7);
         req = 4'b0000;
      end
      idle("single_end", 1);

      // round robin, pointer back to 0 first
      do_reset();
      req_state = 8'b11_10_01_00;
`ifdef INDICATOR_PREEMPT_EN
      req = 4'b1110;
      for (int d = 0; d < 5; d++)
         for (int k = 0; k < 8; k++)
            tick("rr", 2'(1 + d % 3), 4'(4'b0001 << (1 + d % 3)), 1'b1, k == 7);
`else
      req = 4'b1111;
      for (int d = 0; d < 5; d++)
         for (int k = 0; k < 8; k++)
            tick("rr", 2'(d % 4), 4'(4'b0001 << (d % 4)), 1'b1, k == 7);
`endif
      req = 4'b0000;
      idle("rr_end", 1);

      // capture and hold: code changes and owner drops mid-dwell
      req = 4'b0010;
      req_state = 8'b00_00_01_00;
      for (int k = 0; k < 8; k++) begin
         tick("hold", 2'd1, 4'b0010, 1'b1, k == 7);
         if (k == 1) req_state = 8'b00_00_10_00;
         if (k == 2) req = 4'b0000;
      end
      idle("hold_end", 1);

      // reset in cycle 4 of a dwell, then pointer restarts at 0
      req = 4'b0100;
      req_state = 8'b00_11_00_00;
      for (int k = 0; k < 4; k++) tick("pre_rst", 2'd3, 4'b0100, 1'b1, 1'b0);
      rst = 1'b1;
      req = 4'b0000;
      idle("mid_rst", 1);
      rst = 1'b0;
      req = 4'b1010;
      req_state = 8'b10_00_01_00;
      for (int k = 0; k < 8; k++) begin
         tick("post_rst", 2'd1, 4'b0010, 1'b1, k == 7);
         req = 4'b0000;
      end
      idle("post_rst_end", 1);

      // requester 0 rises in cycle 3 of requester 2's dwell
      req = 4'b0100;
      req_state = 8'b00_11_00_10;
      for (int k = 0; k < 3; k++) begin
         tick("owner2", 2'd3, 4'b0100, 1'b1, 1'b0);
         req = 4'b0000;
      end
      req = 4'b0001;
`ifdef INDICATOR_PREEMPT_EN
      for (int k = 0; k < 8; k++) begin
         tick("preempt", 2'd2, 4'b0001, 1'b1, k == 7);
         if (k == 5) req = 4'b0000;
      end
`else
      for (int k = 3; k < 8; k++) tick("no_preempt", 2'd3, 4'b0100, 1'b1, k == 7);
      for (int k = 0; k < 8; k++) begin
         tick("after_owner2", 2'd2, 4'b0001, 1'b1, k == 7);
         req = 4'b0000;
      end
`endif
      idle("final", 2);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
